// File: rtl/if_fetch_queue_pkg.sv
// Shared fetch-side types and constants for the IF instruction queue.
package if_fetch_queue_pkg;

   typedef logic [31:0] inst_addr_t;   // InstAddrBus 31:0
   typedef logic [31:0] inst_t;        // InstBus 31:0

   localparam inst_addr_t ZeroWord    = 32'h0000_0000;
   localparam logic       RstnEnable  = 1'b0;
   localparam logic       RstnDisable = 1'b1;
   localparam logic       ChipEnable  = 1'b1;
   localparam logic       ChipDisable = 1'b0;

   // One queued fetch: address plus the ROM word read for it.
   typedef struct packed {
      inst_addr_t pc;
      inst_t      inst;
   } fq_entry_t;

   localparam int unsigned EntryW = $bits(fq_entry_t);

   // Occupancy action for one cycle, encoded as {pop, push}.
   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_PUSH = 2'b01,
      OP_POP  = 2'b10,
      OP_BOTH = 2'b11
   } fq_op_e;

   function automatic fq_op_e fq_op(input logic push, input logic pop);
      return fq_op_e'({pop, push});
   endfunction

endpackage

// File: rtl/if_fetch_queue_if.sv
// Fetch/decode handshake bundle between PC register, ROM, queue and IF/ID.
interface if_fetch_queue_if
   import if_fetch_queue_pkg::*;
#(
   parameter int unsigned PTR_W = 2
) ();

   logic             if_ce;
   inst_addr_t       if_pc;
   inst_t            if_inst;
   logic             flush;
   logic             id_ready;
   logic             id_valid;
   inst_addr_t       id_pc;
   inst_t            id_inst;
   logic             fetch_stall;
   logic [PTR_W:0]   count;

   // Fetch/decode environment side.
   modport master (
      output if_ce, if_pc, if_inst, flush, id_ready,
      input  id_valid, id_pc, id_inst, fetch_stall, count
   );

   // Queue side.
   modport slave (
      input  if_ce, if_pc, if_inst, flush, id_ready,
      output id_valid, id_pc, id_inst, fetch_stall, count
   );

endinterface

// File: rtl/if_fetch_queue_mem.sv
// DEPTH-entry storage array: synchronous write, combinational read, no reset.
module fetch_queue_mem #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned PTR_W  = 2,
   parameter int unsigned DATA_W = 64
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [PTR_W-1:0]  i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [PTR_W-1:0]  i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   // Write the selected entry on an enabled cycle; contents need no reset.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch queue between PC register/ROM and IF/ID: pointers, occupancy,
// valid/ready handshake, full-driven stall and flush.
module if_fetch_queue
   import if_fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PTR_W = 2
) (
   input  logic            clk,
   input  logic            rst,
   if_fetch_queue_if.slave bus
);

   localparam logic [PTR_W:0]   CntFull = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   CntOne  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PtrOne  = PTR_W'(1);

   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;

   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   fq_entry_t        w_wr_entry;
   fq_entry_t        w_rd_entry;
   logic [EntryW-1:0] w_rdata;

   // Status comes from the registered count only, so a pop cannot make
   // room for a push in the same cycle (no combinational ready path).
   assign w_full  = (r_count == CntFull);
   assign w_empty = (r_count == '0);

   assign w_push  = (bus.if_ce == ChipEnable) & ~w_full & ~bus.flush;
   assign w_pop   = ~w_empty & bus.id_ready & ~bus.flush;

   assign w_wr_entry.pc   = bus.if_pc;
   assign w_wr_entry.inst = bus.if_inst;
   assign w_rd_entry      = w_rdata;

   fetch_queue_mem #(
      .DEPTH  (DEPTH),
      .PTR_W  (PTR_W),
      .DATA_W (EntryW)
   ) u_mem (
      .i_clk   (clk),
      .i_we    (w_push),
      .i_waddr (r_wr_ptr),
      .i_wdata (w_wr_entry),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rdata)
   );

   assign bus.id_valid    = ~w_empty;
   assign bus.id_pc       = w_empty ? ZeroWord : w_rd_entry.pc;
   assign bus.id_inst     = w_empty ? ZeroWord : w_rd_entry.inst;
   assign bus.fetch_stall = w_full;
   assign bus.count       = r_count;

   // Pointer and occupancy update; flush empties the queue and wins over push/pop.
   always_ff @(posedge clk or negedge rst) begin
      if (rst == RstnEnable) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (bus.flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PtrOne;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PtrOne;
         end
         unique case (fq_op(w_push, w_pop))
            OP_PUSH: r_count <= r_count + CntOne;
            OP_POP:  r_count <= r_count - CntOne;
            OP_IDLE,
            OP_BOTH: r_count <= r_count;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed self-checking bench for if_fetch_queue (DEPTH=4).
module tb_if_fetch_queue;
   import if_fetch_queue_pkg::*;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned PTR_W = 2;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   int   nf;
   int   np;
   logic acc;
   logic pop;

   if_fetch_queue_if #(.PTR_W(PTR_W)) bus ();

   if_fetch_queue #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Independent ROM model: every pc maps to a distinct word.
   function automatic logic [31:0] rom(input logic [31:0] pc);
      return pc ^ 32'h1300_0013;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [31:0] pc);
      bus.if_ce   = 1'b1;
      bus.if_pc   = pc;
      bus.if_inst = rom(pc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b0;
      bus.if_ce    = 1'b0;
      bus.if_pc    = '0;
      bus.if_inst  = '0;
      bus.flush    = 1'b0;
      bus.id_ready = 1'b0;
      #1;
      chk("rst_valid", bus.id_valid, 0);
      chk("rst_count", bus.count, 0);
      chk("rst_stall", bus.fetch_stall, 0);
      chk("rst_pc",    bus.id_pc, 0);
      chk("rst_inst",  bus.id_inst, 0);
      @(negedge clk);
      rst = 1'b1;

      // Streaming with id_ready=1: one entry in flight, one pc per cycle.
      fetch(32'h0); bus.id_ready = 1'b1;
      tick();
      chk("t1_valid", bus.id_valid, 1);
      chk("t1_pc0",   bus.id_pc, 32'h0);
      chk("t1_inst0", bus.id_inst, rom(32'h0));
      chk("t1_cnt0",  bus.count, 1);
      chk("t1_stl0",  bus.fetch_stall, 0);
      fetch(32'h4);
      tick();
      chk("t1_pc4",   bus.id_pc, 32'h4);
      chk("t1_cnt4",  bus.count, 1);
      fetch(32'h8);
      tick();
      chk("t1_pc8",   bus.id_pc, 32'h8);
      chk("t1_inst8", bus.id_inst, rom(32'h8));
      chk("t1_cnt8",  bus.count, 1);
      chk("t1_stl8",  bus.fetch_stall, 0);

      // Flush with nothing fetched to start the next test empty.
      bus.if_ce = 1'b0; bus.id_ready = 1'b0; bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      chk("clr_count", bus.count, 0);
      chk("clr_valid", bus.id_valid, 0);

      // Fill to full with id_ready=0.
      fetch(32'h0); tick(); chk("t2_cnt1", bus.count, 1); chk("t2_head", bus.id_pc, 32'h0);
      fetch(32'h4); tick(); chk("t2_cnt2", bus.count, 2);
      fetch(32'h8); tick(); chk("t2_cnt3", bus.count, 3); chk("t2_stl3", bus.fetch_stall, 0);
      fetch(32'hC); tick(); chk("t2_cnt4", bus.count, 4); chk("t2_stl4", bus.fetch_stall, 1);
      fetch(32'h10);
      tick();
      chk("t2_held_cnt",  bus.count, 4);
      chk("t2_held_stl",  bus.fetch_stall, 1);
      chk("t2_held_head", bus.id_pc, 32'h0);
      tick();
      chk("t2_held_cnt2", bus.count, 4);

      // One pop from full: push refused that cycle, accepted the next.
      bus.id_ready = 1'b1;
      tick();
      chk("t3_pop_cnt",  bus.count, 3);
      chk("t3_pop_stl",  bus.fetch_stall, 0);
      chk("t3_pop_head", bus.id_pc, 32'h4);
      bus.id_ready = 1'b0;
      tick();
      chk("t3_refill_cnt", bus.count, 4);
      chk("t3_refill_stl", bus.fetch_stall, 1);
      bus.if_ce = 1'b0; bus.id_ready = 1'b1;
      tick(); chk("t3_pc8",  bus.id_pc, 32'h8);  chk("t3_c3", bus.count, 3);
      tick(); chk("t3_pcC",  bus.id_pc, 32'hC);  chk("t3_c2", bus.count, 2);
      tick(); chk("t3_pc10", bus.id_pc, 32'h10); chk("t3_i10", bus.id_inst, rom(32'h10));
      tick();
      chk("t3_empty_cnt",  bus.count, 0);
      chk("t3_empty_vld",  bus.id_valid, 0);
      chk("t3_empty_pc",   bus.id_pc, 0);
      chk("t3_empty_inst", bus.id_inst, 0);
      tick();
      chk("t3_rdy_empty_cnt", bus.count, 0);
      chk("t3_rdy_empty_vld", bus.id_valid, 0);

      // Flush with three queued, a live fetch and id_ready all in the same cycle.
      bus.id_ready = 1'b0;
      fetch(32'h100); tick();
      fetch(32'h104); tick();
      fetch(32'h108); tick();
      chk("t4_cnt3", bus.count, 3);
      bus.flush = 1'b1; fetch(32'h10C); bus.id_ready = 1'b1;
      tick();
      chk("t4_fl_cnt",  bus.count, 0);
      chk("t4_fl_vld",  bus.id_valid, 0);
      chk("t4_fl_pc",   bus.id_pc, 0);
      chk("t4_fl_inst", bus.id_inst, 0);
      bus.flush = 1'b0; bus.id_ready = 1'b0; fetch(32'h200);
      tick();
      chk("t4_resume_cnt",  bus.count, 1);
      chk("t4_resume_pc",   bus.id_pc, 32'h200);
      chk("t4_resume_inst", bus.id_inst, rom(32'h200));
      fetch(32'h204); tick();
      fetch(32'h208); tick();
      fetch(32'h20C); tick();
      chk("t4_full_stl", bus.fetch_stall, 1);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      chk("t4_fl_full_stl", bus.fetch_stall, 0);
      chk("t4_fl_full_cnt", bus.count, 0);

      // Wrap-around stream: 10 fetches, id_ready toggling, order preserved.
      nf = 0; np = 0;
      fetch(32'h300); bus.id_ready = 1'b1;
      for (int c = 0; c < 80 && !(np == 10 && bus.count == 0); c++) begin
         acc = bus.if_ce & ~bus.fetch_stall;
         pop = bus.id_valid & bus.id_ready;
         if (pop) begin
            chk("t5_order_pc",   bus.id_pc,   32'(32'h300 + 4 * np));
            chk("t5_order_inst", bus.id_inst, rom(32'(32'h300 + 4 * np)));
            np++;
         end
         chk("t5_count_le4", {31'b0, (bus.count > 3'd4)}, 0);
         tick();
         if (acc) begin
            nf++;
            if (nf < 10) fetch(32'(32'h300 + 4 * nf));
            else bus.if_ce = 1'b0;
         end
         bus.id_ready = ~bus.id_ready;
      end
      chk("t5_fetched", nf, 10);
      chk("t5_popped",  np, 10);
      chk("t5_drained", bus.count, 0);

      // Asynchronous reset between edges while full.
      bus.id_ready = 1'b0;
      fetch(32'h400); tick();
      fetch(32'h404); tick();
      fetch(32'h408); tick();
      fetch(32'h40C); tick();
      chk("t6_pre_stl", bus.fetch_stall, 1);
      fetch(32'h410);
      #3;
      rst = 1'b0;
      #1;
      chk("t6_async_vld", bus.id_valid, 0);
      chk("t6_async_cnt", bus.count, 0);
      chk("t6_async_stl", bus.fetch_stall, 0);
      chk("t6_async_pc",  bus.id_pc, 0);
      bus.if_ce = 1'b0;
      #2;
      rst = 1'b1;
      tick();
      chk("t6_post_cnt", bus.count, 0);
      chk("t6_post_vld", bus.id_valid, 0);
      fetch(32'h500);
      tick();
      bus.if_ce = 1'b0;
      chk("t6_new_cnt", bus.count, 1);
      chk("t6_new_pc",  bus.id_pc, 32'h500);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Fetch-side instruction queue directly downstream of the PC register and instruction ROM.
- Each enabled fetch cycle it captures the {pc, instruction} pair presented by the PC register and the combinational ROM.
- It presents the oldest pair to the IF/ID stage under a valid/ready handshake.
- It back-pressures the PC register with a stall when full, and is cleared by a branch/exception flush.

Parameters:
- DEPTH, 4, number of {pc, inst} entries; power of two, min 2.
- PTR_W, 2, pointer width = log2(DEPTH).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
- if_ce  input  1  fetch enable from PC register; 1 = if_pc/if_inst form a valid fetch this cycle.
- if_pc  input  32  fetch address from PC register.
- if_inst  input  32  instruction word from ROM for if_pc (combinational, same cycle).
- flush  input  1  discard all queued and in-flight entries.
- id_ready  input  1  decode stage accepts head entry this cycle.
- id_valid  output  1  head entry valid.
- id_pc  output  32  head entry pc; 32'h00000000 when empty.
- id_inst  output  32  head entry instruction; 32'h00000000 (NOP) when empty.
- fetch_stall  output  1  to PC register: hold pc and ce this cycle.
- count  output  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst=0, async):
  - wr_ptr=0, rd_ptr=0, count=0, id_valid=0, id_pc=0, id_inst=0, fetch_stall=0.
  - Storage contents are don't-care.
- Derived signals, combinational from registered count:
  - full = (count==DEPTH); empty = (count==0).
  - fetch_stall = full, combinational.
  - Contract: the PC register holds if_pc/if_ce unchanged while fetch_stall=1, so the refused fetch is re-presented and not lost.
- push = if_ce & ~full & ~flush. On push, write {if_pc, if_inst} at wr_ptr and increment wr_ptr (wraps DEPTH-1 -> 0).
- pop = id_valid & id_ready & ~flush. On pop, increment rd_ptr (wraps).
- Output timing:
  - id_valid = ~empty.
  - id_pc/id_inst = mem[rd_ptr] when ~empty, else zero.
  - No fall-through: a pushed word becomes visible at the output one cycle after the push edge. Minimum fetch-to-ID latency is 1 cycle.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Simultaneous push and pop when not full: both take effect; count unchanged.
- Full with pop in the same cycle: push is refused (full is registered) and the pop proceeds. fetch_stall deasserts next cycle and the held fetch is accepted then. One bubble cycle is accepted as the cost.
- Empty with id_ready=1: no pop, count stays 0, outputs stay zero.
- Flush has priority over push and pop:
  - Next edge: wr_ptr=rd_ptr=0, count=0.
  - id_valid drops the cycle after flush.
  - The if_inst presented in the flush cycle is discarded.
  - fetch_stall deasserts the cycle after flush.
- if_ce=0: no push; the queue drains normally.
- Reset mid-operation: all state returns to reset values immediately; no partial entry survives.
- Widths: count is PTR_W+1 bits so DEPTH is representable. Pointers are PTR_W bits with natural wrap.

Decomposition:
- Shared defines file:
  - InstAddrBus (31:0), InstBus (31:0), ZeroWord (32'h0).
  - New RstnEnable (1'b0) and RstnDisable (1'b1) for active-low reset.
  - ChipEnable/ChipDisable for if_ce comparisons.
- Sub-module fetch_queue_mem: DEPTH x 64-bit register array with synchronous write (we, waddr, wdata) and combinational read (raddr, rdata), no reset on storage.
- Top holds the pointers, count, handshake and flush logic.

Test Plan:
- Reset release, if_ce=1, pc 0,4,8,..., id_ready=1 -> id_valid rises 1 cycle after first push; id_pc sequence 0x0,0x4,0x8 one per cycle; count steady at 1; fetch_stall=0.
- id_ready=0, 4 fetches pc 0x0..0xC -> count=4, fetch_stall=1 from cycle after 4th push; held pc 0x10 not enqueued; id_pc=0x0 held.
- From full, id_ready=1 for one cycle -> pop 0x0; next cycle fetch_stall=0 and pc 0x10 pushed; count returns to 4; output order 0x4,0x8,0xC,0x10.
- Queue holds 3 entries, flush=1 with if_ce=1 and id_ready=1 -> next cycle count=0, id_valid=0, id_pc=0, id_inst=0; flush-cycle fetch not stored; push resumes the following cycle.
- Wrap-around: stream 10 fetches with id_ready toggling 1,0,1,0 -> all 10 pcs emerge in order with no loss or duplication; count never exceeds 4.
- Assert rst=0 asynchronously mid-stream between clock edges -> id_valid, count, fetch_stall go to 0 immediately, without waiting for a clock edge.
